// File: rtl/spiregs_ext.sv
// spiregs_ext: SPI-command register bank feeding the core.
// Handles the reset request pulse, keyboard matrix, hand controllers, keyboard
// FIFO with consumer pop, and video mode.
// Define SPIREGS_READBACK_EN to enable the STATUS readback command (20h).
// Without it, spi_txdata and spi_txdata_valid are tied low.
module spiregs_ext #(
   parameter int KBBUF_DEPTH        = 16,
   parameter int NUM_HCTRL          = 2,
   parameter int RESET_PULSE_CYCLES = 16,
   parameter int VIDMODE_W          = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   spi_msg_end,
   input  logic [7:0]             spi_cmd,
   input  logic [63:0]            spi_rxdata,
   output logic [63:0]            spi_txdata,
   output logic                   spi_txdata_valid,
   output logic                   reset_req,
   output logic                   reset_req_cold,
   output logic [63:0]            keys,
   output logic [8*NUM_HCTRL-1:0] hctrl,
   output logic [7:0]             kbbuf_data,
   output logic                   kbbuf_valid,
   input  logic                   kbbuf_rd,
   output logic                   kbbuf_overflow,
   output logic [VIDMODE_W-1:0]   video_mode
);

   localparam int AW = $clog2(KBBUF_DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = $clog2(RESET_PULSE_CYCLES + 1);
   localparam int HW = 8 * NUM_HCTRL;

   localparam logic [7:0] CMD_RESET   = 8'h01;
   localparam logic [7:0] CMD_KEYS    = 8'h10;
   localparam logic [7:0] CMD_HCTRL   = 8'h11;
   localparam logic [7:0] CMD_PUSH    = 8'h12;
   localparam logic [7:0] CMD_FLUSH   = 8'h13;
   localparam logic [7:0] CMD_VIDMODE = 8'h40;

   logic [RW-1:0] rst_cnt;
   logic          rst_cold;

   logic [7:0]    fifo_mem [KBBUF_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] fill;
   logic          ovf;

   logic do_reset, do_keys, do_hctrl, do_push, do_flush, do_vidmode;
   logic fifo_full, pop, push_ok;

   // Command decode: only a completed message acts.
   always_comb begin
      do_reset   = 1'b0;
      do_keys    = 1'b0;
      do_hctrl   = 1'b0;
      do_push    = 1'b0;
      do_flush   = 1'b0;
      do_vidmode = 1'b0;
      if (spi_msg_end) begin
         case (spi_cmd)
            CMD_RESET:   do_reset   = 1'b1;
            CMD_KEYS:    do_keys    = 1'b1;
            CMD_HCTRL:   do_hctrl   = 1'b1;
            CMD_PUSH:    do_push    = 1'b1;
            CMD_FLUSH:   do_flush   = 1'b1;
            CMD_VIDMODE: do_vidmode = 1'b1;
            default:     ;
         endcase
      end
   end

   // FIFO handshake: a pop frees a slot for a push landing on the same edge.
   always_comb begin
      fifo_full = (fill == CW'(KBBUF_DEPTH));
      pop       = kbbuf_rd && (fill != '0);
      push_ok   = do_push && (!fifo_full || pop);
   end

   // Reset pulse down-counter; cold qualifier accumulates across reloads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_cnt  <= '0;
         rst_cold <= 1'b0;
      end else if (do_reset) begin
         rst_cnt  <= RW'(RESET_PULSE_CYCLES);
         rst_cold <= (reset_req & rst_cold) | spi_rxdata[57];
      end else if (rst_cnt != '0) begin
         rst_cnt <= rst_cnt - 1'b1;
         if (rst_cnt == RW'(1)) rst_cold <= 1'b0;
      end
   end

   assign reset_req      = (rst_cnt != '0);
   assign reset_req_cold = rst_cold;

   // Plain configuration registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         keys       <= '1;
         hctrl      <= '1;
         video_mode <= '0;
      end else begin
         if (do_keys)    keys       <= spi_rxdata;
         if (do_hctrl)   hctrl      <= spi_rxdata[63 -: HW];
         if (do_vidmode) video_mode <= spi_rxdata[56 +: VIDMODE_W];
      end
   end

   // FIFO pointers, fill count and sticky overflow; flush overrides a pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         ovf    <= 1'b0;
      end else if (do_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         ovf    <= 1'b0;
      end else begin
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         fill <= fill + CW'(push_ok) - CW'(pop);
         if (do_push && !push_ok) ovf <= 1'b1;
      end
   end

   // FIFO storage; contents need no reset since validity comes from fill.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= spi_rxdata[63:56];
   end

   assign kbbuf_data     = fifo_mem[rd_ptr];
   assign kbbuf_valid    = (fill != '0);
   assign kbbuf_overflow = ovf;

`ifdef SPIREGS_READBACK_EN
   localparam logic [7:0] CMD_STATUS = 8'h20;

   logic [7:0]  fill_sat;
   logic [63:0] status;

   // Status word assembled from live state.
   always_comb begin
      fill_sat = (32'(fill) > 32'd255) ? 8'hFF : 8'(fill);
      status   = {fill_sat, ovf, reset_req, 6'b0, 8'(video_mode), 40'b0};
   end

   // Readback tracks spi_cmd every cycle, no msg_end needed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spi_txdata       <= '0;
         spi_txdata_valid <= 1'b0;
      end else begin
         spi_txdata_valid <= (spi_cmd == CMD_STATUS);
         spi_txdata       <= (spi_cmd == CMD_STATUS) ? status : '0;
      end
   end
`else
   assign spi_txdata       = '0;
   assign spi_txdata_valid = 1'b0;
`endif

endmodule

// File: doc/spiregs_ext.md
Name: spiregs_ext

Overview:
SPI-command register bank for the core. It sits between the SPI slave (decoded cmd/rxdata/msg_end) and core consumers: keyboard matrix, hand controllers, keyboard buffer, video mode and reset requests. It generalises the fixed register set with a parametrised hand-controller count, a real keyboard FIFO with consumer pop, a stretched reset pulse, a wider video mode and optional status readback to the host.

Parameters:
KBBUF_DEPTH, 16, keyboard FIFO entries; power of two, 2..256
NUM_HCTRL, 2, hand-controller channels, 1..8
RESET_PULSE_CYCLES, 16, reset_req pulse length in clk cycles, >=1
VIDMODE_W, 2, video mode width, 1..8

Ports:
clk  in  1  core clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
spi_msg_end  in  1  one-cycle strobe, message complete
spi_cmd  in  8  current command byte
spi_rxdata  in  64  message payload, first byte in [63:56]
spi_txdata  out  64  readback data
spi_txdata_valid  out  1  readback data valid
reset_req  out  1  core reset request (stretched)
reset_req_cold  out  1  cold-reset qualifier, valid while reset_req=1
keys  out  64  keyboard matrix, active-low
hctrl  out  8*NUM_HCTRL  channel i = hctrl[8i+7:8i], active-low
kbbuf_data  out  8  FIFO head byte (show-ahead)
kbbuf_valid  out  1  FIFO non-empty
kbbuf_rd  in  1  consumer pop
kbbuf_overflow  out  1  sticky: push dropped while full
video_mode  out  VIDMODE_W  video mode select

Behaviour:
- Commands act only on the clk edge where spi_msg_end=1; they take effect on outputs one cycle later.
- Reset values: reset_req=0, reset_req_cold=0, keys=all 1s, hctrl=all 1s, FIFO empty (kbbuf_valid=0, kbbuf_data don't-care), kbbuf_overflow=0, video_mode=0, spi_txdata=0, spi_txdata_valid=0. Reset mid-pulse aborts the pulse. Reset mid-readback drops valid.
- 01h RESET: loads the down-counter with RESET_PULSE_CYCLES. reset_req=1 while counter!=0, giving exactly RESET_PULSE_CYCLES cycles. reset_req_cold = rxdata[57], latched at start. A new 01h during a pulse reloads the counter; cold becomes the OR of old and new cold. reset_req_cold clears when the pulse ends.
- 10h KEYS: keys <= rxdata.
- 11h HCTRL: hctrl <= rxdata[63 : 64-8*NUM_HCTRL]. The highest channel takes rxdata[63:56].
- 12h KBBUF push: pushes rxdata[63:56].
  - When full and no pop in the same cycle, the byte is dropped and kbbuf_overflow is set.
  - When full and kbbuf_rd=1 in the same cycle, both the pop and the push happen and there is no overflow.
- 13h KBBUF flush: empties the FIFO and clears kbbuf_overflow. If a pop occurs in the same cycle, the flush wins.
- Pop: kbbuf_rd=1 with kbbuf_valid=1 advances the head next cycle. kbbuf_rd while empty is ignored.
- FIFO: pointers wrap modulo KBBUF_DEPTH. Fill count is log2(KBBUF_DEPTH)+1 bits, so full is distinguishable from empty. A byte pushed into an empty FIFO appears on kbbuf_data/kbbuf_valid one cycle after the push edge.
- 40h VIDMODE: video_mode <= rxdata[56 +: VIDMODE_W].
- Unknown commands are ignored. spi_cmd without spi_msg_end changes nothing.

Optional Feature:
SPIREGS_READBACK_EN.
- Defined: command 20h STATUS. When spi_cmd==20h, spi_txdata and spi_txdata_valid are registered one cycle later and update every cycle while spi_cmd stays 20h. spi_txdata_valid drops one cycle after spi_cmd changes.
- STATUS layout:
  - [63:56] FIFO fill count, zero-extended, saturated at 255
  - [55] kbbuf_overflow
  - [54] reset_req
  - [47:40] video_mode, zero-extended
  - all other bits 0
- Undefined: spi_txdata=0 and spi_txdata_valid=0 constantly, and 20h is ignored.

Test Plan:
- Reset release: all outputs at reset values; keys=FFFF_FFFF_FFFF_FFFF; hctrl=FFFF (NUM_HCTRL=2).
- 01h with rxdata[57]=1 -> reset_req and reset_req_cold high for exactly 16 cycles. A second 01h (cold=0) at cycle 10 -> pulse extends to cycle 26 and cold stays 1.
- 11h with rxdata=0x12345678_00000000 -> hctrl=0x1234 one cycle after msg_end. 40h with rxdata[57:56]=2'b10 -> video_mode=2.
- Push 16 bytes 0x00..0x0F, then a 17th (0xAA) -> overflow=1 and 0xAA dropped. Pop 16 -> data 0x00..0x0F in order, then kbbuf_valid=0.
- With FIFO full, push 0x55 in the same cycle as kbbuf_rd -> overflow stays 0, count stays 16, and 0x55 is the last byte out. 13h -> count 0, overflow 0.
- With SPIREGS_READBACK_EN and 3 bytes queued plus overflow set: hold spi_cmd=20h -> next cycle valid=1 and txdata[63:56]=03, [55]=1. Change cmd -> valid=0 one cycle later. With the macro undefined, valid stays 0.
